// File: rtl/ipf_sched.sv
// ipf_sched: job scheduler for the IPF datapath.
// Loads the input rows once per job, then for each weight group streams that
// group's weight words, issues a RUN_LEN-cycle compute window, and
// cross-checks the datapath's result-valid pulses against that window.
module ipf_sched #(
   parameter int N_ROWS  = 8,
   parameter int RUN_LEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  cfg_groups,
   input  logic [63:0] s_i_data,
   input  logic        s_i_valid,
   output logic        s_i_ready,
   input  logic [63:0] s_w_data,
   input  logic        s_w_valid,
   output logic        s_w_ready,
   output logic [1:0]  ipf_ctrl,
   output logic [63:0] ipf_i_data,
   output logic        ipf_i_valid,
   output logic [63:0] ipf_w_data,
   output logic        ipf_w_valid,
   input  logic        ipf_res_valid,
   input  logic        ipf_finish,
   output logic        busy,
   output logic        done,
   output logic [3:0]  grp_idx,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_I,
      S_LOAD_W,
      S_ISSUE,
      S_RUN,
      S_DRAIN,
      S_FIN,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      CTRL_END   = 2'd0,
      CTRL_START = 2'd1,
      CTRL_HOLD  = 2'd2
   } ctrl_t;

   localparam logic [3:0] C_N_ROWS   = 4'(N_ROWS);
   localparam logic [5:0] C_RUN_LEN  = 6'(RUN_LEN);
   // RUN occupies RUN_LEN-1 cycles; the counter starts at 0 on RUN entry.
   localparam logic [5:0] C_RUN_LAST = 6'(RUN_LEN - 2);

   state_t      r_state;
   state_t      w_next;
   ctrl_t       w_ctrl;
   logic        w_busy;
   logic        w_done;

   logic [3:0]  r_row_cnt;
   logic [2:0]  r_word_cnt;
   logic [5:0]  r_run_cnt;
   logic [5:0]  r_res_cnt;
   logic [3:0]  r_groups;
   logic [3:0]  r_grp;
   logic        r_err;
   logic        r_was_done;

   logic [63:0] r_i_data;
   logic        r_i_valid;
   logic [63:0] r_w_data;
   logic        r_w_valid;

   logic [2:0]  w_quota;
   logic        w_i_ready;
   logic        w_w_ready;
   logic        w_i_acc;
   logic        w_w_acc;
   logic        w_rows_full;
   logic        w_words_full;
   logic        w_run_last;
   logic        w_last_grp;
   logic        w_start_ok;
   logic        w_res_window;
   logic [5:0]  w_res_total;

   // Handshake and progress decode from the registered state and counters.
   always_comb begin
      w_quota      = r_grp[0] ? 3'd4 : 3'd5;
      w_i_ready    = (r_state == S_LOAD_I) && (r_row_cnt < C_N_ROWS);
      w_w_ready    = (r_state == S_LOAD_W) && (r_word_cnt < w_quota);
      w_i_acc      = s_i_valid && w_i_ready;
      w_w_acc      = s_w_valid && w_w_ready;
      w_rows_full  = (r_row_cnt == C_N_ROWS);
      w_words_full = (r_word_cnt == w_quota);
      w_run_last   = (r_run_cnt == C_RUN_LAST);
      w_last_grp   = ((r_grp + 4'd1) == r_groups);
      w_start_ok   = start && (cfg_groups != '0);
      w_res_window = (r_state == S_RUN) || (r_state == S_DRAIN);
      w_res_total  = r_res_cnt + {5'd0, ipf_res_valid};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_next = r_state;
      w_ctrl = CTRL_HOLD;
      w_busy = 1'b1;
      w_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_start_ok) begin
               w_next = S_LOAD_I;
            end
         end
         S_LOAD_I: begin
            if (w_rows_full) begin
               w_next = S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (w_words_full) begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_ctrl = CTRL_START;
            w_next = S_RUN;
         end
         S_RUN: begin
            w_ctrl = CTRL_START;
            if (w_run_last) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_next = w_last_grp ? S_FIN : S_LOAD_W;
         end
         S_FIN: begin
            w_ctrl = CTRL_END;
            w_next = S_DONE;
         end
         S_DONE: begin
            w_busy = 1'b0;
            w_done = 1'b1;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Row, word, run and result counters plus the group bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_row_cnt  <= '0;
         r_word_cnt <= '0;
         r_run_cnt  <= '0;
         r_res_cnt  <= '0;
         r_groups   <= '0;
         r_grp      <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            r_row_cnt <= '0;
         end else if (w_i_acc) begin
            r_row_cnt <= r_row_cnt + 4'd1;
         end

         if (r_state != S_LOAD_W) begin
            r_word_cnt <= '0;
         end else if (w_w_acc) begin
            r_word_cnt <= r_word_cnt + 3'd1;
         end

         if (r_state == S_RUN) begin
            r_run_cnt <= r_run_cnt + 6'd1;
         end else begin
            r_run_cnt <= '0;
         end

         // The window opens the cycle after ISSUE; DRAIN's own sample is
         // folded in combinationally when the total is judged.
         if (r_state == S_ISSUE) begin
            r_res_cnt <= '0;
         end else if ((r_state == S_RUN) && ipf_res_valid) begin
            r_res_cnt <= r_res_cnt + 6'd1;
         end

         if ((r_state == S_IDLE) && w_start_ok) begin
            r_groups <= cfg_groups;
            r_grp    <= '0;
         end else if ((r_state == S_DRAIN) && !w_last_grp) begin
            r_grp <= r_grp + 4'd1;
         end
      end
   end

   // Forward each accepted stream beat to the datapath one cycle later.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_i_data  <= '0;
         r_i_valid <= 1'b0;
         r_w_data  <= '0;
         r_w_valid <= 1'b0;
      end else begin
         r_i_valid <= w_i_acc;
         r_w_valid <= w_w_acc;
         if (w_i_acc) begin
            r_i_data <= s_i_data;
         end
         if (w_w_acc) begin
            r_w_data <= s_w_data;
         end
      end
   end

   // Sticky error: stray results, wrong result count per group, or the
   // datapath not reporting finish on the first DONE cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_err      <= 1'b0;
         r_was_done <= 1'b0;
      end else begin
         r_was_done <= (r_state == S_DONE);
         if (ipf_res_valid && !w_res_window) begin
            r_err <= 1'b1;
         end
         if ((r_state == S_DRAIN) && (w_res_total != C_RUN_LEN)) begin
            r_err <= 1'b1;
         end
         if ((r_state == S_DONE) && !r_was_done && !ipf_finish) begin
            r_err <= 1'b1;
         end
      end
   end

   assign s_i_ready   = w_i_ready;
   assign s_w_ready   = w_w_ready;
   assign ipf_ctrl    = w_ctrl;
   assign ipf_i_data  = r_i_data;
   assign ipf_i_valid = r_i_valid;
   assign ipf_w_data  = r_w_data;
   assign ipf_w_valid = r_w_valid;
   assign busy        = w_busy;
   assign done        = w_done;
   assign grp_idx     = r_grp;
   assign err         = r_err;

endmodule
